time_convert_scheduler: RTL and testbench
=========================================

TIME_CONVERT_SCHEDULER -- requirements
Module: time_convert_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 3, meaning the number of requesters sharing the converter.
REQ-002 The block SHALL have parameter SEC_W, default 64, meaning the width of each total-seconds operand.
REQ-003 The block SHALL have port clk_500Hz  input  1  system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port req  input  NUM_REQ  level request per requester; held until its done.
REQ-006 The block SHALL have port total_seconds_bus  input  NUM_REQ*SEC_W  operand of requester k at bits [k*SEC_W +: SEC_W].
REQ-007 The block SHALL have port grant  output  NUM_REQ  one-hot requester being served; all-zero when idle.
REQ-008 The block SHALL have port busy  output  1  high in every non-IDLE state.
REQ-009 The block SHALL have port done  output  1  single-cycle pulse when results are valid.
REQ-010 The block SHALL have port done_id  output  2  index of the requester whose result is presented.
REQ-011 The block SHALL have ports hours, minutes and seconds  output  6 each  converted result, held until the next done.
REQ-012 The block SHALL have port overflow  output  1  result was saturated; held with the result.

Function
REQ-013 The states SHALL be IDLE, DIV_H, DIV_M and DONE.
REQ-014 In IDLE with any req bit set, the block SHALL grant round-robin: search starts at pointer ptr, wrapping modulo NUM_REQ.
REQ-015 At the grant edge the block SHALL latch the granted operand and set grant, then go to DIV_H; later operand changes are ignored.
REQ-016 DIV_H SHALL last exactly 64 cycles, computing Q = operand / 3600 and R = operand % 3600 (restoring shift-subtract).
REQ-017 DIV_M SHALL last exactly 12 cycles, computing R / 60 and R % 60, with R treated as 12 bits.
REQ-018 DONE SHALL last 1 cycle, and in it the block SHALL register the outputs, pulse done, drive done_id, and set ptr to granted index + 1 mod NUM_REQ.
REQ-019 The block SHALL return to IDLE after DONE, clearing grant.
REQ-020 If the grant is at cycle N, DIV_H SHALL occupy cycles N+1..N+64, DIV_M N+65..N+76 and DONE N+77; a new grant is possible at N+78 at the earliest.
REQ-021 If Q > 63, the block SHALL output 63/59/59 and set overflow=1; otherwise it SHALL output Q, R/60 and R%60 with overflow=0.
REQ-022 If a requester deasserts req mid-conversion, the conversion SHALL still complete and done SHALL still pulse.
REQ-023 A requester holding req across its own done SHALL be eligible again, with the lowest priority after ptr rotation.
REQ-024 A req bit rising while busy SHALL wait; there is no preemption.

Reset
REQ-025 While rst_n=0 the block SHALL asynchronously force state=IDLE, ptr=0, grant=0, busy=0, done=0, done_id=0, hours=minutes=seconds=0 and overflow=0.
REQ-026 Reset mid-conversion SHALL abort the conversion with no done pulse; after release, arbitration SHALL restart from ptr=0.

Structure
REQ-027 A shared package SHALL hold SEC_PER_HOUR=3600, SEC_PER_MIN=60, DIV_H_CYCLES=64, DIV_M_CYCLES=12, HOURS_MAX=63 and the state encoding.
REQ-028 A sub-module time_div_unit SHALL provide a reusable iterative restoring divider with ports start, dividend, divisor and iteration count, and outputs quotient, remainder and valid, used for both phases.

Verification
REQ-029 The bench SHALL cover: req=001, operand 3661 -> done at grant+77, hours=1, minutes=1, seconds=1, overflow=0, done_id=0.
REQ-030 The bench SHALL cover: operand 0 and operand 230399 -> 0/0/0 and 63/59/59 respectively, both with overflow=0.
REQ-031 The bench SHALL cover: operand 230400 and operand 2^64-1 -> 63/59/59 with overflow=1.
REQ-032 The bench SHALL cover: req=111 held throughout -> done_id sequence 0,1,2,0, and grants spaced 78 cycles apart.
REQ-033 The bench SHALL cover: rst_n pulsed low at grant+30 -> all outputs 0 immediately, no done, and the next service goes to requester 0 first.
REQ-034 The bench SHALL cover: requester 1 drops req at grant+10 and its operand changes -> done pulses with the result of the originally latched value.

Source files
------------

// File: rtl/time_convert_scheduler_pkg.sv
// Shared constants, FSM encoding and result payload for the time converter.
package time_convert_scheduler_pkg;

  localparam int unsigned SEC_PER_HOUR = 3600;
  localparam int unsigned SEC_PER_MIN  = 60;
  localparam int unsigned DIV_H_CYCLES = 64;
  localparam int unsigned DIV_M_CYCLES = 12;
  localparam int unsigned HOURS_MAX    = 63;
  localparam int unsigned MS_MAX       = 59;
  localparam int unsigned REM_H_W      = 12;  // remainder of /3600 always fits in 12 bits
  localparam int unsigned ID_W         = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DIV_H = 2'd1;
  localparam logic [1:0] ST_DIV_M = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef struct packed {
    logic [5:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       overflow;
  } hms_t;

endpackage

// File: rtl/time_div_unit.sv
// Iterative restoring divider. start loads the operands and performs the first
// step in the same cycle; each following cycle performs one more step. valid
// pulses for one cycle once 'iters' steps are done. The dividend is treated as
// an iters-bit value (its top W-iters bits must be zero).
// Ports: clk, rst_n, start, dividend, divisor, iters -> quotient, remainder, valid.
module time_div_unit #(
  parameter int unsigned W     = 64,
  parameter int unsigned CNT_W = $clog2(W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [W-1:0]     dividend,
  input  logic [W-1:0]     divisor,
  input  logic [CNT_W-1:0] iters,
  output logic [W-1:0]     quotient,
  output logic [W-1:0]     remainder,
  output logic             valid
);

  logic [W-1:0]     rem_q, rem_d;
  logic [W-1:0]     quo_q, quo_d;
  logic [W-1:0]     div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;

  logic [W-1:0]     src_rem, src_quo, src_div;
  logic [W:0]       shifted;

  // One shift-subtract step on either the freshly loaded or the running operands.
  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    src_rem = rem_q;
    src_quo = quo_q;
    src_div = div_q;
    if (start) begin
      src_rem = '0;
      // Pre-align so the iters-bit dividend's MSB is shifted out first.
      src_quo = dividend << (CNT_W'(W) - iters);
      src_div = divisor;
      div_d   = divisor;
    end
    shifted = {src_rem, src_quo[W-1]};
    if (start || (cnt_q != '0)) begin
      if (shifted >= {1'b0, src_div}) begin
        rem_d = W'(shifted - {1'b0, src_div});
        quo_d = {src_quo[W-2:0], 1'b1};
      end else begin
        rem_d = W'(shifted);
        quo_d = {src_quo[W-2:0], 1'b0};
      end
      cnt_d   = start ? (iters - CNT_W'(1)) : (cnt_q - CNT_W'(1));
      valid_d = start ? (iters == CNT_W'(1)) : (cnt_q == CNT_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign valid     = valid_q;

endmodule

// File: rtl/time_convert_scheduler.sv
// Round-robin scheduler sharing one divider that converts total seconds into
// hours/minutes/seconds, saturating at 63:59:59.
// Ports: clk_500Hz, rst_n, req, total_seconds_bus -> grant, busy, done, done_id,
//        hours, minutes, seconds, overflow.
module time_convert_scheduler
  import time_convert_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned SEC_W   = 64
) (
  input  logic                     clk_500Hz,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*SEC_W-1:0] total_seconds_bus,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               done_id,
  output logic [5:0]               hours,
  output logic [5:0]               minutes,
  output logic [5:0]               seconds,
  output logic                     overflow
);

  localparam int unsigned CNT_W = $clog2(SEC_W + 1);
  localparam logic [SEC_W-1:0] REM_MASK = SEC_W'((1 << REM_H_W) - 1);

  logic [1:0]         state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    gnt_idx_q, gnt_idx_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [ID_W-1:0]    done_id_q, done_id_d;
  hms_t               res_q, res_d;
  logic [5:0]         hrs_q, hrs_d;
  logic               ovf_q, ovf_d;

  logic               found;
  logic [ID_W-1:0]    sel_idx;
  int                 idx;
  logic [SEC_W-1:0]   sel_operand;

  logic               div_start;
  logic [SEC_W-1:0]   div_dividend, div_divisor;
  logic [CNT_W-1:0]   div_iters;
  logic [SEC_W-1:0]   div_quo, div_rem;
  logic               div_valid;

  // Round-robin pick: first requester at or after ptr, wrapping.
  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    idx     = 0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      idx = (int'(ptr_q) + i) % int'(NUM_REQ);
      if (!found && req[idx]) begin
        found   = 1'b1;
        sel_idx = ID_W'(idx);
      end
    end
    sel_operand = total_seconds_bus[int'(sel_idx)*SEC_W +: SEC_W];
  end

  time_div_unit #(.W(SEC_W), .CNT_W(CNT_W)) u_div (
    .clk       (clk_500Hz),
    .rst_n     (rst_n),
    .start     (div_start),
    .dividend  (div_dividend),
    .divisor   (div_divisor),
    .iters     (div_iters),
    .quotient  (div_quo),
    .remainder (div_rem),
    .valid     (div_valid)
  );

  // Next-state, divider sequencing and output staging.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    gnt_idx_d    = gnt_idx_q;
    grant_d      = grant_q;
    done_d       = 1'b0;
    done_id_d    = done_id_q;
    res_d        = res_q;
    hrs_d        = hrs_q;
    ovf_d        = ovf_q;
    div_start    = 1'b0;
    div_dividend = sel_operand;
    div_divisor  = SEC_W'(SEC_PER_HOUR);
    div_iters    = CNT_W'(DIV_H_CYCLES);
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d   = ST_DIV_H;
          gnt_idx_d = sel_idx;
          grant_d   = NUM_REQ'(1) << sel_idx;
          div_start = 1'b1;
        end
      end
      ST_DIV_H: begin
        if (div_valid) begin
          state_d      = ST_DIV_M;
          hrs_d        = div_quo[5:0];
          ovf_d        = |div_quo[SEC_W-1:6];
          div_start    = 1'b1;
          div_dividend = div_rem & REM_MASK;
          div_divisor  = SEC_W'(SEC_PER_MIN);
          div_iters    = CNT_W'(DIV_M_CYCLES);
        end
      end
      ST_DIV_M: begin
        if (div_valid) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d   = ST_IDLE;
        grant_d   = '0;
        done_d    = 1'b1;
        done_id_d = gnt_idx_q;
        ptr_d     = (gnt_idx_q == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx_q + ID_W'(1);
        if (ovf_q) begin
          res_d.hours    = 6'(HOURS_MAX);
          res_d.minutes  = 6'(MS_MAX);
          res_d.seconds  = 6'(MS_MAX);
          res_d.overflow = 1'b1;
        end else begin
          res_d.hours    = hrs_q;
          res_d.minutes  = div_quo[5:0];
          res_d.seconds  = div_rem[5:0];
          res_d.overflow = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_500Hz or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      gnt_idx_q <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      res_q     <= '0;
      hrs_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_idx_q <= gnt_idx_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      res_q     <= res_d;
      hrs_q     <= hrs_d;
      ovf_q     <= ovf_d;
    end
  end

  assign grant    = grant_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign done_id  = done_id_q;
  assign hours    = res_q.hours;
  assign minutes  = res_q.minutes;
  assign seconds  = res_q.seconds;
  assign overflow = res_q.overflow;

endmodule

// File: tb/tb_time_convert_scheduler.sv
// Scoreboard bench for time_convert_scheduler: expected results are queued as
// requests are issued and compared when done pulses.
module tb_time_convert_scheduler;

  localparam int NUM_REQ = 3;
  localparam int SEC_W   = 64;

  logic                     clk_500Hz = 1'b0;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*SEC_W-1:0] total_seconds_bus;
  logic [NUM_REQ-1:0]       grant;
  logic                     busy;
  logic                     done;
  logic [1:0]               done_id;
  logic [5:0]               hours, minutes, seconds;
  logic                     overflow;

  typedef struct {
    logic [1:0] id;
    logic [5:0] h;
    logic [5:0] m;
    logic [5:0] s;
    logic       ovf;
  } exp_t;

  exp_t   sb[$];
  longint grant_cycles[$];
  logic [NUM_REQ-1:0] grant_vals[$];
  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;
  longint grant_cyc = 0;

  always #5 clk_500Hz = ~clk_500Hz;
  always @(posedge clk_500Hz) cyc <= cyc + 1;

  time_convert_scheduler #(.NUM_REQ(NUM_REQ), .SEC_W(SEC_W)) dut (
    .clk_500Hz         (clk_500Hz),
    .rst_n             (rst_n),
    .req               (req),
    .total_seconds_bus (total_seconds_bus),
    .grant             (grant),
    .busy              (busy),
    .done              (done),
    .done_id           (done_id),
    .hours             (hours),
    .minutes           (minutes),
    .seconds           (seconds),
    .overflow          (overflow)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input int id, input logic [63:0] t);
    exp_t e;
    e.id = 2'(id);
    if (t / 64'd3600 > 64'd63) begin
      e.h = 6'd63; e.m = 6'd59; e.s = 6'd59; e.ovf = 1'b1;
    end else begin
      e.h = 6'(t / 64'd3600);
      e.m = 6'((t % 64'd3600) / 64'd60);
      e.s = 6'(t % 64'd60);
      e.ovf = 1'b0;
    end
    return e;
  endfunction

  // Monitor: grant rise times and scoreboard comparison on every done.
  initial begin
    logic [NUM_REQ-1:0] prev_grant;
    exp_t e;
    prev_grant = '0;
    forever begin
      @(negedge clk_500Hz);
      if (grant != '0 && prev_grant == '0) begin
        grant_cyc = cyc;
        grant_cycles.push_back(cyc);
        grant_vals.push_back(grant);
      end
      prev_grant = grant;
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("done_id",  64'(done_id),  64'(e.id));
          check("hours",    64'(hours),    64'(e.h));
          check("minutes",  64'(minutes),  64'(e.m));
          check("seconds",  64'(seconds),  64'(e.s));
          check("overflow", 64'(overflow), 64'(e.ovf));
          check("done_latency", 64'(cyc - grant_cyc), 64'd77);
        end
      end
    end
  end

  task automatic wait_grant();
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk_500Hz);
      if (grant != '0) seen = 1;
    end
    if (!seen) check("grant_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk_500Hz);
      if (done === 1'b1) seen = 1;
    end
    if (!seen) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_grant"},   64'(grant),    64'd0);
    check({tag, "_busy"},    64'(busy),     64'd0);
    check({tag, "_done"},    64'(done),     64'd0);
    check({tag, "_done_id"}, 64'(done_id),  64'd0);
    check({tag, "_hms"},     64'({hours, minutes, seconds}), 64'd0);
    check({tag, "_ovf"},     64'(overflow), 64'd0);
  endtask

  task automatic run_one(input int id, input logic [63:0] op);
    total_seconds_bus[id*SEC_W +: SEC_W] = op;
    sb.push_back(model(id, op));
    req[id] = 1'b1;
    wait_grant();
    check("grant_onehot", 64'(grant), 64'd1 << id);
    check("busy_active",  64'(busy),  64'd1);
    wait_done();
    req[id] = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk_500Hz);
    rst_n = 1'b1;
    @(negedge clk_500Hz);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    req = '0;
    total_seconds_bus = '0;
    repeat (3) @(negedge clk_500Hz);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk_500Hz);

    // Single conversions, including the hour-saturation boundaries.
    run_one(0, 64'd3661);
    run_one(1, 64'd0);
    run_one(2, 64'd230399);
    run_one(0, 64'd230400);
    run_one(1, 64'hFFFF_FFFF_FFFF_FFFF);
    for (int i = 0; i < 4; i++) run_one(i % 3, 64'($urandom_range(0, 300000)));

    // Requester 1 drops req and changes its operand mid-conversion.
    total_seconds_bus[1*SEC_W +: SEC_W] = 64'd7322;
    sb.push_back(model(1, 64'd7322));
    req[1] = 1'b1;
    wait_grant();
    repeat (10) @(negedge clk_500Hz);
    req[1] = 1'b0;
    total_seconds_bus[1*SEC_W +: SEC_W] = 64'd999999;
    wait_done();
    repeat (3) @(negedge clk_500Hz);
    check("hold_hours", 64'(hours), 64'd2);
    check("done_single_pulse", 64'(done), 64'd0);

    // Reset mid-conversion; ptr is 2 here, so a grant to 0 proves the restart.
    total_seconds_bus[1*SEC_W +: SEC_W] = 64'd5000;
    req = 3'b010;
    wait_grant();
    check("pre_rst_grant", 64'(grant), 64'd2);
    repeat (30) @(negedge clk_500Hz);
    rst_n = 1'b0;
    #1;
    check_zero("rst_async");
    total_seconds_bus[0*SEC_W +: SEC_W] = 64'd45296;
    total_seconds_bus[2*SEC_W +: SEC_W] = 64'd100;
    req = 3'b111;
    repeat (2) @(negedge clk_500Hz);
    check_zero("rst_hold");
    sb.push_back(model(0, 64'd45296));
    rst_n = 1'b1;
    wait_grant();
    check("post_rst_grant", 64'(grant), 64'd1);
    wait_done();
    req = '0;

    // All three held: rotation 0,1,2,0 with 78-cycle grant spacing.
    pulse_reset();
    grant_cycles.delete();
    grant_vals.delete();
    total_seconds_bus[0*SEC_W +: SEC_W] = 64'd59;
    total_seconds_bus[1*SEC_W +: SEC_W] = 64'd3600;
    total_seconds_bus[2*SEC_W +: SEC_W] = 64'd86399;
    sb.push_back(model(0, 64'd59));
    sb.push_back(model(1, 64'd3600));
    sb.push_back(model(2, 64'd86399));
    sb.push_back(model(0, 64'd59));
    req = 3'b111;
    for (int k = 0; k < 4; k++) wait_done();
    req = '0;
    check("rr_grant_count", 64'(grant_vals.size()), 64'd4);
    for (int k = 0; k < grant_vals.size() && k < 4; k++) begin
      check("rr_grant_order", 64'(grant_vals[k]), 64'd1 << (k % 3));
      if (k > 0) check("rr_spacing", 64'(grant_cycles[k] - grant_cycles[k-1]), 64'd78);
    end

    repeat (5) @(negedge clk_500Hz);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
